// File: rtl/bmp280_avalon_arbiter_if.sv
// ---------------------------------------------------------------------------
// bmp280_avalon_arbiter_if
// Purpose : one Avalon-MM link (address/command/data plus response signals).
//           Used three times around the arbiter: BMP280 master link, host
//           master link and the shared slave link.
// Modports: master - the side that issues commands (drives address, read,
//                    write, byteenable, writedata; receives readdata,
//                    readdatavalid, waitrequest)
//           slave  - the side that answers commands (mirror of master)
// ---------------------------------------------------------------------------
interface bmp280_avalon_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0]   writedata;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/bmp280_avalon_arbiter.sv
// ---------------------------------------------------------------------------
// bmp280_avalon_arbiter
// Purpose : round-robin arbiter sharing one Avalon-MM slave between the BMP280
//           sampling engine (m0) and a host master (m1). One transaction is in
//           flight at a time; reads wait in RDWAIT until readdatavalid or a
//           timeout, which returns 0xDEADBEEF and sets a sticky error flag.
// Ports   : clk         system clock
//           rst_n       synchronous reset, active low
//           m0, m1      master links (arbiter acts as their slave)
//           s           shared slave link (arbiter acts as its master)
//           timeout_err sticky read-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module bmp280_avalon_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bmp280_avalon_arbiter_if.slave  m0,
    bmp280_avalon_arbiter_if.slave  m1,
    bmp280_avalon_arbiter_if.master s,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic            ptr_reg;      // master that wins a simultaneous request
    logic            grant_reg;    // master owning the current transaction
    logic [AW-1:0]   s_address_reg;
    logic            s_read_reg;
    logic            s_write_reg;
    logic [DW/8-1:0] s_byteenable_reg;
    logic [DW-1:0]   s_writedata_reg;
    logic [15:0]     cnt_reg;
    logic            timeout_err_reg;

    logic            req0;
    logic            req1;
    logic            win;
    logic            accept;
    logic            timeout_hit;
    logic            rd_done;
    logic [DW-1:0]   rd_data;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Contention goes to the pointer; otherwise whoever asks.
    assign win = (req0 && req1) ? ptr_reg : req1;

    assign accept = (state_reg == CMD) && !s.waitrequest;

    // cnt_reg is 0 in the first RDWAIT cycle, so the timeout response is
    // produced in the cycle after RD_TIMEOUT full cycles of waiting.
    assign timeout_hit = (state_reg == RDWAIT) && (cnt_reg == 16'(RD_TIMEOUT));
    assign rd_done     = (state_reg == RDWAIT) && (s.readdatavalid || timeout_hit);

    // Real slave data wins over a timeout landing in the same cycle.
    assign rd_data = (timeout_hit && !s.readdatavalid) ? DW'(32'hDEAD_BEEF) : s.readdata;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (accept) begin
                    state_next = s_read_reg ? RDWAIT : IDLE;
                end
            end
            RDWAIT: begin
                if (rd_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        m0.waitrequest   = 1'b1;
        m1.waitrequest   = 1'b1;
        m0.readdatavalid = 1'b0;
        m1.readdatavalid = 1'b0;
        m0.readdata      = rd_data;
        m1.readdata      = rd_data;
        case (state_reg)
            CMD: begin
                // Only the granted master sees the slave's stall.
                if (grant_reg) begin
                    m1.waitrequest = s.waitrequest;
                end else begin
                    m0.waitrequest = s.waitrequest;
                end
            end
            RDWAIT: begin
                m0.readdatavalid = rd_done && !grant_reg;
                m1.readdatavalid = rd_done && grant_reg;
            end
            default: begin
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg          <= 1'b0;
            grant_reg        <= 1'b0;
            s_address_reg    <= '0;
            s_read_reg       <= 1'b0;
            s_write_reg      <= 1'b0;
            s_byteenable_reg <= '0;
            s_writedata_reg  <= '0;
            cnt_reg          <= 16'd0;
            timeout_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_reg        <= win;
                        s_address_reg    <= win ? m1.address    : m0.address;
                        s_byteenable_reg <= win ? m1.byteenable : m0.byteenable;
                        s_writedata_reg  <= win ? m1.writedata  : m0.writedata;
                        // read+write together is a read; the write is dropped
                        s_read_reg       <= win ? m1.read : m0.read;
                        s_write_reg      <= win ? (m1.write && !m1.read)
                                                : (m0.write && !m0.read);
                    end
                end
                CMD: begin
                    if (accept) begin
                        s_read_reg  <= 1'b0;
                        s_write_reg <= 1'b0;
                        ptr_reg     <= ~grant_reg;
                        cnt_reg     <= 16'd0;
                    end
                end
                RDWAIT: begin
                    cnt_reg <= cnt_reg + 16'd1;
                    if (timeout_hit && !s.readdatavalid) begin
                        timeout_err_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s.address    = s_address_reg;
    assign s.read       = s_read_reg;
    assign s.write      = s_write_reg;
    assign s.byteenable = s_byteenable_reg;
    assign s.writedata  = s_writedata_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_bmp280_avalon_arbiter.sv
module tb_bmp280_avalon_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic timeout_err;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bmp280_avalon_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
    bmp280_avalon_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
    bmp280_avalon_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

    bmp280_avalon_arbiter #(.AW(AW), .DW(DW), .RD_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic        m0r, m0w;
        logic [31:0] a0, wd0;
        logic        m1r, m1w;
        logic [31:0] a1;
        logic        swait, srdv;
        logic [31:0] srd;
        logic        e_sread, e_swrite;
        logic [31:0] e_addr, e_wd;
        logic        e_w0, e_w1, e_v0, e_v1;
        logic [31:0] e_rdata;
        logic        e_terr;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic sr, input logic sw,
                           input logic w0, input logic w1, input logic v0, input logic v1);
        chk({name, ".s_read"}, 32'(s_bus.read), 32'(sr));
        chk({name, ".s_write"}, 32'(s_bus.write), 32'(sw));
        chk({name, ".m0_wait"}, 32'(m0_bus.waitrequest), 32'(w0));
        chk({name, ".m1_wait"}, 32'(m1_bus.waitrequest), 32'(w1));
        chk({name, ".m0_valid"}, 32'(m0_bus.readdatavalid), 32'(v0));
        chk({name, ".m1_valid"}, 32'(m1_bus.readdatavalid), 32'(v1));
    endtask

    task automatic idle_inputs();
        m0_bus.read = 0; m0_bus.write = 0; m0_bus.address = 0; m0_bus.writedata = 0;
        m1_bus.read = 0; m1_bus.write = 0; m1_bus.address = 0; m1_bus.writedata = 0;
        s_bus.waitrequest = 0; s_bus.readdatavalid = 0; s_bus.readdata = 0;
    endtask

    // Drive m0 read to addr, run CMD (accepted at once), then RDWAIT cycles;
    // on RDWAIT cycle valid_at the slave returns data (valid_at > 8: never).
    task automatic timed_read(input string name, input logic [31:0] addr,
                              input int valid_at, input logic [31:0] data);
        @(negedge clk); idle_inputs(); m0_bus.read = 1; m0_bus.address = addr;
        #2 chk_bus({name, "_idle"}, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        #2 chk_bus({name, "_cmd"}, 1, 0, 0, 1, 0, 0);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk); m0_bus.read = 0;
            s_bus.readdatavalid = (k == valid_at); s_bus.readdata = data;
            #2;
            if (k < 8 && k != valid_at) begin
                chk_bus($sformatf("%s_wait%0d", name, k), 0, 0, 1, 1, 0, 0);
            end else begin
                chk_bus($sformatf("%s_resp%0d", name, k), 0, 0, 1, 1, 1, 0);
                chk({name, "_rdata"}, m0_bus.readdata, (k == valid_at) ? data : 32'hDEAD_BEEF);
                chk({name, "_terr_resp"}, 32'(timeout_err), 32'(0));
                break;
            end
        end
        @(negedge clk); idle_inputs();
        #2 chk_bus({name, "_post"}, 0, 0, 1, 1, 0, 0);
    endtask

    initial begin
        // m0a0 wd0 m1 a1 wt rdv srd | sread swr addr wd w0 w1 v0 v1 rdata terr
        vecs[0]  = '{1,0,32'h20,0, 1,0,32'h30, 0,0,0,            0,0,32'h00,0, 1,1,0,0,0,0};
        vecs[1]  = '{1,0,32'h20,0, 1,0,32'h30, 0,0,0,            1,0,32'h20,0, 0,1,0,0,0,0};
        vecs[2]  = '{0,0,0,0,      1,0,32'h30, 0,0,0,            0,0,32'h20,0, 1,1,0,0,0,0};
        vecs[3]  = '{0,0,0,0,      1,0,32'h30, 0,1,32'hA0A00000, 0,0,32'h20,0, 1,1,1,0,32'hA0A00000,0};
        vecs[4]  = '{0,0,0,0,      1,0,32'h30, 0,0,0,            0,0,32'h20,0, 1,1,0,0,0,0};
        vecs[5]  = '{0,0,0,0,      1,0,32'h30, 0,0,0,            1,0,32'h30,0, 1,0,0,0,0,0};
        vecs[6]  = '{0,0,0,0,      0,0,0,      0,0,0,            0,0,32'h30,0, 1,1,0,0,0,0};
        vecs[7]  = '{0,0,0,0,      0,0,0,      0,1,32'hB1B10001, 0,0,32'h30,0, 1,1,0,1,32'hB1B10001,0};
        vecs[8]  = '{0,0,0,0,      0,0,0,      0,0,0,            0,0,32'h30,0, 1,1,0,0,0,0};
        vecs[9]  = '{0,1,32'h10,32'hCAFE0001, 0,0,0, 0,0,0,      0,0,32'h30,0, 1,1,0,0,0,0};
        vecs[10] = '{0,1,32'h10,32'hCAFE0001, 0,0,0, 0,0,0,      0,1,32'h10,32'hCAFE0001, 0,1,0,0,0,0};
        vecs[11] = '{0,0,0,0,      0,0,0,      0,0,0,            0,0,32'h10,32'hCAFE0001, 1,1,0,0,0,0};
        vecs[12] = '{0,0,0,0,      0,0,0,      0,1,32'hFFFFFFFF, 0,0,32'h10,32'hCAFE0001, 1,1,0,0,0,0};
        vecs[13] = '{0,0,0,0,      1,1,32'h40, 0,0,0,            0,0,32'h10,32'hCAFE0001, 1,1,0,0,0,0};
        vecs[14] = '{0,0,0,0,      1,1,32'h40, 0,0,0,            1,0,32'h40,0, 1,0,0,0,0,0};
        vecs[15] = '{0,0,0,0,      0,0,0,      0,1,32'h12345678, 0,0,32'h40,0, 1,1,0,1,32'h12345678,0};
        vecs[16] = '{0,0,0,0,      0,0,0,      0,0,0,            0,0,32'h40,0, 1,1,0,0,0,0};

        rst_n = 0;
        idle_inputs();
        m0_bus.byteenable = 4'hF;
        m1_bus.byteenable = 4'h3;
        repeat (3) @(posedge clk);
        @(negedge clk); s_bus.readdatavalid = 1;
        #2 chk_bus("reset", 0, 0, 1, 1, 0, 0);
        chk("reset.s_address", s_bus.address, 0);
        chk("reset.s_byteenable", 32'(s_bus.byteenable), 0);
        chk("reset.s_writedata", s_bus.writedata, 0);
        chk("reset.timeout_err", 32'(timeout_err), 0);
        s_bus.readdatavalid = 0;
        rst_n = 1;

        // Table: T2 (simultaneous reads), T1 (write), stray valid, read+write
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            m0_bus.read = vecs[i].m0r; m0_bus.write = vecs[i].m0w;
            m0_bus.address = vecs[i].a0; m0_bus.writedata = vecs[i].wd0;
            m1_bus.read = vecs[i].m1r; m1_bus.write = vecs[i].m1w;
            m1_bus.address = vecs[i].a1; m1_bus.writedata = 0;
            s_bus.waitrequest = vecs[i].swait; s_bus.readdatavalid = vecs[i].srdv;
            s_bus.readdata = vecs[i].srd;
            #2;
            chk_bus($sformatf("vec%0d", i), vecs[i].e_sread, vecs[i].e_swrite,
                    vecs[i].e_w0, vecs[i].e_w1, vecs[i].e_v0, vecs[i].e_v1);
            chk($sformatf("vec%0d.s_address", i), s_bus.address, vecs[i].e_addr);
            chk($sformatf("vec%0d.s_writedata", i), s_bus.writedata, vecs[i].e_wd);
            chk($sformatf("vec%0d.timeout_err", i), 32'(timeout_err), 32'(vecs[i].e_terr));
            if (vecs[i].e_v0) chk($sformatf("vec%0d.m0_readdata", i), m0_bus.readdata, vecs[i].e_rdata);
            if (vecs[i].e_v1) chk($sformatf("vec%0d.m1_readdata", i), m1_bus.readdata, vecs[i].e_rdata);
            if (i == 10) chk("vec10.s_byteenable", 32'(s_bus.byteenable), 32'hF);
            $display("vec %0d: s_read=%0b s_write=%0b s_address=%h v0=%0b v1=%0b",
                     i, s_bus.read, s_bus.write, s_bus.address,
                     m0_bus.readdatavalid, m1_bus.readdatavalid);
        end

        // T3: m1 write stalled 5 cycles, m0 read waits behind it
        @(negedge clk); idle_inputs();
        m1_bus.write = 1; m1_bus.address = 32'h50; m1_bus.writedata = 32'h5555AAAA;
        s_bus.waitrequest = 1;
        #2 chk_bus("t3_idle", 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); m0_bus.read = 1; m0_bus.address = 32'h60;
            #2 chk_bus($sformatf("t3_stall%0d", k), 0, 1, 1, 1, 0, 0);
            chk($sformatf("t3_stall%0d.s_address", k), s_bus.address, 32'h50);
            chk($sformatf("t3_stall%0d.s_writedata", k), s_bus.writedata, 32'h5555AAAA);
            chk($sformatf("t3_stall%0d.s_byteenable", k), 32'(s_bus.byteenable), 32'h3);
        end
        @(negedge clk); s_bus.waitrequest = 0;
        #2 chk_bus("t3_accept", 0, 1, 1, 0, 0, 0);
        @(negedge clk); m1_bus.write = 0;
        #2 chk_bus("t3_after", 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        #2 chk_bus("t3_m0cmd", 1, 0, 0, 1, 0, 0);
        chk("t3_m0cmd.s_address", s_bus.address, 32'h60);
        @(negedge clk); m0_bus.read = 0; s_bus.readdatavalid = 1; s_bus.readdata = 32'h6;
        #2 chk_bus("t3_m0data", 0, 0, 1, 1, 1, 0);
        chk("t3_m0data.readdata", m0_bus.readdata, 32'h6);
        $display("t3: stalled write then queued read done");

        // T4: timeout, then a normal m1 read leaves the flag set
        timed_read("t4", 32'h70, 99, 32'h0);
        chk("t4.timeout_err", 32'(timeout_err), 1);
        m1_bus.read = 1; m1_bus.address = 32'h80;
        @(negedge clk);
        #2 chk_bus("t4_m1cmd", 1, 0, 1, 0, 0, 0);
        @(negedge clk); m1_bus.read = 0; s_bus.readdatavalid = 1; s_bus.readdata = 32'h80808080;
        #2 chk_bus("t4_m1data", 0, 0, 1, 1, 0, 1);
        chk("t4_m1data.readdata", m1_bus.readdata, 32'h80808080);
        @(negedge clk); idle_inputs();
        #2 chk("t4_sticky.timeout_err", 32'(timeout_err), 1);
        $display("t4: timeout response and sticky error done");

        // T6: reset while in RDWAIT abandons the read
        @(negedge clk); m0_bus.read = 1; m0_bus.address = 32'h90;
        @(negedge clk);
        #2 chk_bus("t6_cmd", 1, 0, 0, 1, 0, 0);
        @(negedge clk); m0_bus.read = 0; rst_n = 0;
        #2 chk_bus("t6_rdwait", 0, 0, 1, 1, 0, 0);
        @(negedge clk); s_bus.readdatavalid = 1; s_bus.readdata = 32'h1;
        #2 chk_bus("t6_rst", 0, 0, 1, 1, 0, 0);
        chk("t6_rst.s_address", s_bus.address, 0);
        chk("t6_rst.timeout_err", 32'(timeout_err), 0);
        @(negedge clk); rst_n = 1;
        #2 chk_bus("t6_stray", 0, 0, 1, 1, 0, 0);
        $display("t6: reset mid-read done");

        // T5: slave data on the exact timeout cycle wins
        timed_read("t5", 32'hA0, 8, 32'h00000055);
        chk("t5.timeout_err", 32'(timeout_err), 0);
        $display("t5: valid on timeout cycle done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
